nes_controller_responder: RTL

- Device-side end of the NES serial controller protocol. It emulates a standard 8-button pad so the chip can be read by an NES host or by our own controller receiver, e.g. for loopback bring-up on a second TT tile.
- Samples a parallel button vector on host latch and serialises it on nes_data, one bit per host clock pulse.
- Host latch/clock are asynchronous to clk; the block synchronises them internally.

---
 rtl/nes_controller_responder_pkg.sv | 58 +++++
 rtl/nes_sync_edge.sv | 38 +++
 rtl/nes_controller_responder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/nes_controller_responder_pkg.sv
// ============================================================================
// Module : nes_controller_responder_pkg
// Brief  : Shared constants, state encoding and frame helper for the NES/SNES
//          pad responder. Macro NES_RESPONDER_SNES_EN selects the 16-bit frame.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nes_controller_responder_pkg;

`ifdef NES_RESPONDER_SNES_EN
  localparam int FRAME_BITS = 16;
  localparam int BTN_W      = 12;
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;
`else
  localparam int FRAME_BITS = 8;
  localparam int BTN_W      = 8;
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
`endif

  localparam int CNT_W = $clog2(FRAME_BITS) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Unused trailing frame bits (SNES ID nibble) load as released.
  function automatic logic [FRAME_BITS-1:0] load_frame(input logic [BTN_W-1:0] btn);
    logic [FRAME_BITS-1:0] f;
    f            = '0;
    f[BTN_W-1:0] = btn;
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nes_sync_edge.sv
// ============================================================================
// Module : nes_sync_edge
// Brief  : SYNC_STAGES flop synchroniser with rise/fall pulse detection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nes_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_sr;
  logic                   level_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_sr <= '0;
      level_d <= 1'b0;
    end else begin
      sync_sr <= {sync_sr[SYNC_STAGES-2:0], d};
      level_d <= sync_sr[SYNC_STAGES-1];
    end
  end

  assign level = sync_sr[SYNC_STAGES-1];
  assign rise  = level & ~level_d;
  assign fall  = ~level & level_d;

endmodule

`default_nettype wire

// File: rtl/nes_controller_responder.sv
// ============================================================================
// Module : nes_controller_responder
// Brief  : Device-side NES pad emulator; latches buttons on host latch and
//          shifts them out on nes_data per host clock. Macro
//          NES_RESPONDER_SNES_EN widens to a 12-button, 16-bit SNES frame.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nes_controller_responder
  import nes_controller_responder_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic DONE_LEVEL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BTN_W-1:0] buttons,
  input  logic             nes_latch,
  input  logic             nes_clk,
  output logic             nes_data,
  output logic             busy,
  output logic             read_done
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  logic l_s, l_rise, l_fall;
  logic c_s, c_rise, c_fall;
  logic unused_edges;

  nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (nes_latch),
    .level (l_s),
    .rise  (l_rise),
    .fall  (l_fall)
  );

  nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (nes_clk),
    .level (c_s),
    .rise  (c_rise),
    .fall  (c_fall)
  );

  assign unused_edges = ^{l_rise, c_s, c_fall};

  // Buttons share the latch's delay so the sampled vector lines up with l_s.
  logic [BTN_W-1:0] btn_sync [SYNC_STAGES];
  logic [BTN_W-1:0] buttons_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) btn_sync[i] <= '0;
    end else begin
      btn_sync[0] <= buttons;
      for (int i = 1; i < SYNC_STAGES; i++) btn_sync[i] <= btn_sync[i-1];
    end
  end

  assign buttons_s = btn_sync[SYNC_STAGES-1];

  state_t                state;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      nes_data  <= 1'b1;
      busy      <= 1'b0;
      read_done <= 1'b0;
    end else begin
      read_done <= 1'b0;
      // Latch wins over everything, including an in-flight frame.
      if (l_s) begin
        state     <= ST_LOAD;
        shift_reg <= load_frame(buttons_s);
        bit_cnt   <= '0;
        nes_data  <= ~buttons_s[0];
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            nes_data <= 1'b1;
            busy     <= 1'b0;
          end
          ST_LOAD: begin
            if (l_fall) begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
            end
          end
          ST_SHIFT: begin
            if (c_rise) begin
              shift_reg <= {1'b0, shift_reg[FRAME_BITS-1:1]};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                state     <= ST_DONE;
                read_done <= 1'b1;
                busy      <= 1'b0;
                nes_data  <= DONE_LEVEL;
              end else begin
                nes_data <= ~shift_reg[1];
              end
            end
          end
          ST_DONE: begin
            nes_data <= DONE_LEVEL;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
